// File: rtl/icache_fill_ctrl.sv
// Direct-mapped read-only instruction cache with an 8-word block-fill FSM.
// Define ICACHE_STATS_EN to build saturating hit/miss counters; otherwise both read as zero.
module icache_fill_ctrl #(
    parameter int unsigned IDX_BITS  = 6,
    parameter int unsigned BLK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    input  logic        flush,
    output logic [15:0] instr_out,
    output logic        stall,
    output logic        mem_rd_en,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        mem_data_valid,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int unsigned SETS      = 1 << IDX_BITS;
    localparam int unsigned TAG_BITS  = 12 - IDX_BITS;
    localparam logic [2:0]  LAST_WORD = 3'(BLK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [11:0]           blk_q, blk_d;
    logic [2:0]            issue_cnt_q, issue_cnt_d;
    logic [2:0]            recv_cnt_q, recv_cnt_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [SETS-1:0]       valid_q, valid_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [15:0]           mem_addr_q, mem_addr_d;

    logic [15:0]           data_arr_q [SETS][BLK_WORDS];
    logic [TAG_BITS-1:0]   tag_arr_q  [SETS];
    logic                  data_we;
    logic                  tag_we;

    logic [2:0]            req_off;
    logic [IDX_BITS-1:0]   req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [IDX_BITS-1:0]   fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  miss_start;
    logic                  unused_addr_lsb;

    assign req_off         = fetch_addr[3:1];
    assign req_idx         = fetch_addr[3+IDX_BITS:4];
    assign req_tag         = fetch_addr[15:4+IDX_BITS];
    assign fill_idx        = blk_q[IDX_BITS-1:0];
    assign fill_tag        = blk_q[11:IDX_BITS];
    assign unused_addr_lsb = fetch_addr[0];

    // Lookups are only honoured in IDLE; during a fill the arrays are in flux.
    assign hit        = (state_q == IDLE) & fetch_req & valid_q[req_idx]
                        & (tag_arr_q[req_idx] == req_tag);
    assign miss_start = (state_q == IDLE) & fetch_req & ~hit;

    assign stall     = (state_q != IDLE) | (fetch_req & ~hit);
    assign instr_out = hit ? data_arr_q[req_idx][req_off] : 16'h0000;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;

    always_comb begin
        state_d      = state_q;
        blk_d        = blk_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        mem_rd_en_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (miss_start) begin
                    state_d     = FILL;
                    blk_d       = fetch_addr[15:4];
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = {fetch_addr[15:4], 4'b0000};
                end
                if (flush) begin
                    valid_d = '0;
                end
            end
            FILL, WAIT: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                // Request registers are loaded one cycle ahead so mem_rd_en/mem_addr stay flops.
                if (state_q == FILL) begin
                    issue_cnt_d = issue_cnt_q + 3'd1;
                    if (issue_cnt_q == LAST_WORD) begin
                        state_d = WAIT;
                    end else begin
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = {blk_q, issue_cnt_q + 3'd1, 1'b0};
                    end
                end
                if (mem_data_valid) begin
                    data_we    = 1'b1;
                    recv_cnt_d = recv_cnt_q + 3'd1;
                    if (recv_cnt_q == LAST_WORD) begin
                        state_d      = IDLE;
                        mem_rd_en_d  = 1'b0;
                        flush_pend_d = 1'b0;
                        if (flush_pend_q || flush) begin
                            valid_d = '0;
                        end else begin
                            valid_d[fill_idx] = 1'b1;
                            tag_we            = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            blk_q        <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            blk_q        <= blk_d;
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_arr_q[fill_idx][recv_cnt_q] <= mem_data;
        end
        if (tag_we) begin
            tag_arr_q[fill_idx] <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit && (hit_count_q != 16'hFFFF)) begin
            hit_count_d = hit_count_q + 16'd1;
        end
        if (miss_start && (miss_count_q != 16'hFFFF)) begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule
